// File: rtl/link_rx_sequencer.sv
// rtl/link_rx_sequencer.sv - receive sequencer for the inter-board serial link
module link_rx_sequencer #(
  parameter int         DATA_BITS  = 256,
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         HUNT_LIMIT = 32
) (
  input  logic                 clkIn,
  input  logic                 rst,
  input  logic                 rxEnable,
  input  logic                 remoteReady,
  input  logic                 dataIn,
  output logic                 readyForReceive,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rxBuffer,
  output logic                 frameToggle,
  output logic                 crcErr,
  output logic [7:0]           errCount
);

  localparam int CNT_MAX = (DATA_BITS > HUNT_LIMIT) ? DATA_BITS : HUNT_LIMIT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 en_meta, en_sync;
  logic [7:0]           sync_sr, sync_nxt;
  logic [7:0]           chk;
  logic [7:0]           rx_chk, rx_chk_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATA_BITS-1:0] shadow;
  logic [2:0]           chk_idx;
  logic                 data_we;
  logic                 clr_chk;
  logic                 commit;
  logic                 chk_fail;
  logic                 abort;
  logic                 rfr_nxt;

  assign busy    = (state == HUNT) || (state == DATA) || (state == CHECK);
  assign chk_idx = 3'd7 - cnt[2:0];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sync_nxt   = sync_sr;
    rx_chk_nxt = rx_chk;
    data_we    = 1'b0;
    clr_chk    = 1'b0;
    commit     = 1'b0;
    chk_fail   = 1'b0;
    abort      = 1'b0;

    case (state)
      IDLE: begin
        if (remoteReady && readyForReceive) begin
          state_nxt = HUNT;
          cnt_nxt   = '0;
          sync_nxt  = '0;
        end
      end
      HUNT: begin
        sync_nxt = {sync_sr[6:0], dataIn};
        cnt_nxt  = cnt + 1'b1;
        if (!remoteReady) begin
          abort = 1'b1;
        end else if (sync_nxt == SYNC_WORD) begin
          // A match on the timeout edge still wins.
          state_nxt = DATA;
          cnt_nxt   = '0;
          clr_chk   = 1'b1;
        end else if (cnt_nxt == CW'(HUNT_LIMIT)) begin
          abort = 1'b1;
        end
      end
      DATA: begin
        if (!remoteReady) begin
          abort = 1'b1;
        end else begin
          data_we = 1'b1;
          if (cnt == CW'(DATA_BITS - 1)) begin
            state_nxt = CHECK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      CHECK: begin
        if (!remoteReady) begin
          abort = 1'b1;
        end else begin
          rx_chk_nxt = {rx_chk[6:0], dataIn};
          if (cnt == CW'(7)) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            if (rx_chk_nxt == chk) commit = 1'b1;
            else                   chk_fail = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (!remoteReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Ready is offered only while idle and the local switch allows it.
  assign rfr_nxt = (state_nxt == IDLE) && en_sync;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      en_meta         <= 1'b0;
      en_sync         <= 1'b0;
      readyForReceive <= 1'b0;
      sync_sr         <= '0;
      cnt             <= '0;
      chk             <= '0;
      rx_chk          <= '0;
      shadow          <= '0;
      rxBuffer        <= '0;
      frameToggle     <= 1'b0;
      crcErr          <= 1'b0;
      errCount        <= '0;
    end else begin
      en_meta         <= rxEnable;
      en_sync         <= en_meta;
      state           <= state_nxt;
      readyForReceive <= rfr_nxt;
      sync_sr         <= sync_nxt;
      cnt             <= cnt_nxt;
      rx_chk          <= rx_chk_nxt;

      if (clr_chk) begin
        chk <= '0;
      end else if (data_we) begin
        chk[chk_idx] <= chk[chk_idx] ^ dataIn;
      end

      // Shifting MSB-first leaves payload bit n at shadow[DATA_BITS-1-n].
      if (data_we) shadow <= {shadow[DATA_BITS-2:0], dataIn};

      if (commit) begin
        rxBuffer    <= shadow;
        frameToggle <= ~frameToggle;
        crcErr      <= 1'b0;
      end else if (chk_fail) begin
        crcErr <= 1'b1;
      end

      if ((abort || chk_fail) && (errCount != 8'hFF)) errCount <= errCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_link_rx_sequencer.sv
// tb/tb_link_rx_sequencer.sv - directed self-checking bench for link_rx_sequencer
module tb_link_rx_sequencer;

  localparam int DATA_BITS = 256;

  logic                 clkIn = 1'b0;
  logic                 rst = 1'b0;
  logic                 rxEnable = 1'b0;
  logic                 remoteReady = 1'b0;
  logic                 dataIn = 1'b0;
  logic                 readyForReceive;
  logic                 busy;
  logic [DATA_BITS-1:0] rxBuffer;
  logic                 frameToggle;
  logic                 crcErr;
  logic [7:0]           errCount;

  int errors = 0;
  int checks = 0;

  logic [255:0] exp_buf;
  logic         exp_tog;
  logic         exp_crc;
  logic [7:0]   exp_err;

  typedef struct {
    logic [255:0] payload;
    logic [7:0]   chk;
    logic [7:0]   pre;
    int           npre;
    logic         good;
  } vec_t;

  vec_t vecs[6];

  link_rx_sequencer #(
    .DATA_BITS (256),
    .SYNC_WORD (8'hA5),
    .HUNT_LIMIT(32)
  ) dut (
    .clkIn          (clkIn),
    .rst            (rst),
    .rxEnable       (rxEnable),
    .remoteReady    (remoteReady),
    .dataIn         (dataIn),
    .readyForReceive(readyForReceive),
    .busy           (busy),
    .rxBuffer       (rxBuffer),
    .frameToggle    (frameToggle),
    .crcErr         (crcErr),
    .errCount       (errCount)
  );

  always #5 clkIn = ~clkIn;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/rxBuffer"}, rxBuffer, exp_buf);
    check({tag, "/frameToggle"}, frameToggle, exp_tog);
    check({tag, "/crcErr"}, crcErr, exp_crc);
    check({tag, "/errCount"}, errCount, exp_err);
  endtask

  task automatic err_inc();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic send_bit(input logic b);
    dataIn = b;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!readyForReceive && n < 20) begin
      tick();
      n++;
    end
    check("wait_ready", readyForReceive, 1'b1);
  endtask

  task automatic begin_frame();
    wait_ready();
    remoteReady = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    remoteReady = 1'b0;
    tick();
    check("rfr_after_done", readyForReceive, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    begin_frame();
    for (int i = v.npre - 1; i >= 0; i--) send_bit(v.pre[i]);
    send_byte(8'hA5);
    for (int i = 255; i >= 0; i--) send_bit(v.payload[i]);
    send_byte(v.chk);
    if (v.good) begin
      exp_buf = v.payload;
      exp_tog = ~exp_tog;
      exp_crc = 1'b0;
    end else begin
      exp_crc = 1'b1;
      err_inc();
    end
    check_all(tag);
    check({tag, "/busy_done"}, busy, 1'b0);
    check({tag, "/rfr_done"}, readyForReceive, 1'b0);
    tick();
    check({tag, "/rfr_hold"}, readyForReceive, 1'b0);
    end_frame();
  endtask

  initial begin
    vecs[0] = '{payload: {8'hFF, 248'h0}, chk: 8'hFF, pre: 8'h00, npre: 0, good: 1'b1};
    vecs[1] = '{payload: {8'hFF, 248'h0}, chk: 8'h00, pre: 8'h00, npre: 0, good: 1'b0};
    vecs[2] = '{payload: 256'h0, chk: 8'h00, pre: 8'b101, npre: 3, good: 1'b1};
    vecs[3] = '{payload: {8'h12, 8'h34, 240'h0}, chk: 8'h26, pre: 8'h00, npre: 0, good: 1'b1};
    vecs[4] = '{payload: {8'hC3, 8'h3C, 232'h0, 8'h5A}, chk: 8'hA5, pre: 8'h00, npre: 0, good: 1'b1};
    vecs[5] = '{payload: {8'hC3, 8'h3C, 232'h0, 8'h5A}, chk: 8'hA4, pre: 8'h00, npre: 0, good: 1'b0};

    exp_buf = '0;
    exp_tog = 1'b0;
    exp_crc = 1'b0;
    exp_err = 8'h00;

    #1 rst = 1'b1;
    rxEnable = 1'b1;
    #10;
    check_all("reset");
    check("reset/rfr", readyForReceive, 1'b0);
    check("reset/busy", busy, 1'b0);
    #6 rst = 1'b0;

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Hunt timeout after 32 edges without a match
    begin_frame();
    for (int i = 0; i < 31; i++) send_bit(1'b0);
    check("hunt31/busy", busy, 1'b1);
    send_bit(1'b0);
    err_inc();
    check("hunt32/busy", busy, 1'b0);
    check_all("hunt_timeout");

    // Match on the 32nd hunt edge beats the timeout
    begin_frame();
    for (int i = 0; i < 24; i++) send_bit(1'b0);
    send_byte(8'hA5);
    check("match_at_limit/busy", busy, 1'b1);
    check_all("match_at_limit");
    remoteReady = 1'b0;
    tick();
    err_inc();
    check("match_abort/busy", busy, 1'b0);
    check_all("match_abort");

    // Peer drops ready after 100 payload bits
    begin_frame();
    send_byte(8'hA5);
    for (int i = 0; i < 100; i++) send_bit(i[0]);
    remoteReady = 1'b0;
    tick();
    err_inc();
    check("midframe/busy", busy, 1'b0);
    check_all("midframe_drop");
    run_vec(vecs[3], "after_drop");

    // rxEnable dropping mid-frame is ignored; abort on the final checksum edge wins
    begin_frame();
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    rxEnable = 1'b0;
    for (int i = 0; i < 246; i++) send_bit(1'b0);
    check("en_drop/busy", busy, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check_all("chk7_no_commit");
    dataIn = 1'b0;
    remoteReady = 1'b0;
    tick();
    err_inc();
    check("final_abort/busy", busy, 1'b0);
    check("final_abort/rfr", readyForReceive, 1'b0);
    check_all("final_abort");
    rxEnable = 1'b1;

    // Asynchronous reset during DATA, between edges
    begin_frame();
    send_byte(8'hA5);
    for (int i = 0; i < 50; i++) send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    exp_buf = '0;
    exp_tog = 1'b0;
    exp_crc = 1'b0;
    exp_err = 8'h00;
    check_all("async_rst");
    check("async_rst/busy", busy, 1'b0);
    check("async_rst/rfr", readyForReceive, 1'b0);
    #1 rst = 1'b0;

    // 260 aborts saturate the error counter
    for (int i = 0; i < 260; i++) begin
      begin_frame();
      remoteReady = 1'b0;
      tick();
      err_inc();
    end
    check_all("saturate");

    // With rxEnable low the block never offers ready nor leaves IDLE
    remoteReady = 1'b0;
    rxEnable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    remoteReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 4) begin
        check($sformatf("gate%0d/rfr", i), readyForReceive, 1'b0);
        check($sformatf("gate%0d/busy", i), busy, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_rx_sequencer.md
Name: link_rx_sequencer

Overview:
- Receive-side controller for the inter-board serial link; clocked by the peer-supplied serial clock.
- Sequences the readyForReceive / readyForSend handshake, hunts for a sync byte, then shifts in a 256-bit checkers board frame and an 8-bit checksum.
- Commits a checksum-clean frame to the receive buffer that feeds the NIOS row inputs and the board renderer.
- Counts link errors for LED/HEX debug.

Parameters:
- DATA_BITS, 256, board payload bits per frame (multiple of 8).
- SYNC_WORD, 8'hA5, frame start pattern.
- HUNT_LIMIT, 32, clkIn edges allowed in HUNT before abort.

Ports:
- clkIn  input  1  serial clock from peer; all state on posedge.
- rst  input  1  reset.
- rxEnable  input  1  local permission to receive (switch); asynchronous, double-flop synchronized internally.
- remoteReady  input  1  peer readyForSend level.
- dataIn  input  1  serial data, sampled on posedge clkIn.
- readyForReceive  output  1  local ready level to peer.
- busy  output  1  high in HUNT, DATA, CHECK.
- rxBuffer  output  DATA_BITS  last committed good frame.
- frameToggle  output  1  flips once per committed frame; toggle protocol for cross-domain consumers.
- crcErr  output  1  result of last completed frame: 1 = checksum mismatch.
- errCount  output  8  saturating count of aborts and checksum failures.

Behaviour:
- Reset is asynchronous, active-high; clock is clkIn.
- Reset values: state IDLE; readyForReceive 0; busy 0; rxBuffer 0; frameToggle 0; crcErr 0; errCount 0; shadow, sync shift register, checksum register and counter all 0; rxEnable synchronizer 0.
- readyForReceive is registered. It equals 1 only in IDLE with the synchronized rxEnable = 1. It is 0 in all other states.
- IDLE: on an edge with remoteReady = 1 and readyForReceive = 1, go to HUNT and clear sync register and counter. The first link bit is sampled on the following edge.
- HUNT:
  - Shift dataIn into the LSB of the 8-bit sync register; increment the counter.
  - If the value after the shift equals SYNC_WORD: go to DATA, clear the counter, and clear the running checksum.
  - Else if the counter reaches HUNT_LIMIT: abort.
- DATA:
  - Bit n (n = 0..DATA_BITS-1) is written to shadow[DATA_BITS-1-n], MSB first.
  - The same bit is XORed into chk[7 - n[2:0]], so chk holds the XOR of all payload bytes.
  - After bit DATA_BITS-1, go to CHECK with the counter cleared.
- CHECK:
  - Receive 8 checksum bits, MSB first, into rxChk.
  - On the edge sampling the 8th bit, the comparison uses that bit directly; no extra cycle.
  - If match: rxBuffer <= shadow, frameToggle flips, crcErr <= 0.
  - If mismatch: rxBuffer is unchanged, crcErr <= 1, errCount increments.
  - Either way, go to DONE.
- Commit latency: DATA_BITS + 8 edges after the sync-match edge.
- DONE: hold readyForReceive 0. Go to IDLE on the first edge sampling remoteReady = 0. This forces the peer to drop and re-raise readyForSend between frames.
- Abort from HUNT, DATA or CHECK, triggered by remoteReady sampled 0 or by the hunt timeout:
  - Go to IDLE; errCount increments.
  - rxBuffer, frameToggle and crcErr are unchanged; the partial shadow is discarded.
- errCount saturates at 8'hFF.
- rxEnable deasserting mid-frame does not abort. It only blocks re-entry from IDLE.
- Async rst at any point returns all state to reset values immediately, including mid-frame.
- clkIn may stop at any time. The block holds state until the next edge or rst; no timeout runs without clock edges.
- Simultaneous events:
  - remoteReady = 0 on the final CHECK edge: abort takes priority, no commit.
  - Sync match on the edge where the counter reaches HUNT_LIMIT: the match wins.

Test Plan:
- Clean frame: rst pulse; rxEnable = 1; remoteReady = 1; send A5, then 256 bits with byte0 = 8'hFF and all other bytes 0, then checksum FF. Required: rxBuffer[255:248] = FF, rest 0; frameToggle 0->1; crcErr 0; errCount 0; readyForReceive stays 0 until remoteReady drops, then returns to 1.
- Bad checksum: same payload with checksum 8'h00. Required: rxBuffer keeps its prior value; crcErr = 1; errCount = 1; frameToggle unchanged.
- Sync hunt: send 3 garbage bits 101, then A5, then an all-zero payload with checksum 00. Required: commit with rxBuffer = 0 and toggle flips. Separately, send 32 edges of zeros: abort to IDLE, errCount +1.
- Mid-frame drop: drop remoteReady after 100 payload bits. Required: state returns to IDLE; busy = 0; errCount +1; rxBuffer unchanged. A following clean frame commits normally.
- Reset mid-frame: assert rst asynchronously during DATA, between edges. Required: all outputs return to reset values immediately, with no clkIn edge needed.
- Saturation and gating: force 260 aborts; errCount must hold at FF. With rxEnable = 0, remoteReady = 1 and clkIn running: readyForReceive stays 0 and the block stays in IDLE.
